// File: rtl/key_debouncer_if.sv
// -----------------------------------------------------------------------------
// key_debouncer_if
// Bundles the key-facing signals of key_debouncer.
//
// Signals:
//   key_n        raw active-low push-buttons (asynchronous to the clock)
//   key_level    debounced state per key, 1 = pressed
//   key_pressed  one-cycle strobe per accepted press (and per auto-repeat)
//   key_released one-cycle strobe per accepted release
//   fsm_state    debug view of the three per-key FSMs, key 0 in bits [1:0]
//
// Strobe semantics: key_pressed/key_released are pure one-cycle event strobes
// with no ready/backpressure. A consumer must sample them on the cycle they
// are high; nothing is held or retried.
//
// Modports:
//   master  drives key_n, observes the outputs (button model / testbench)
//   slave   the debouncer itself
// -----------------------------------------------------------------------------
interface key_debouncer_if;
   logic [2:0] key_n;
   logic [2:0] key_level;
   logic [2:0] key_pressed;
   logic [2:0] key_released;
   logic [5:0] fsm_state;

   modport master (
      output key_n,
      input  key_level,
      input  key_pressed,
      input  key_released,
      input  fsm_state
   );

   modport slave (
      input  key_n,
      output key_level,
      output key_pressed,
      output key_released,
      output fsm_state
   );
endinterface

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Three-key debouncer running entirely in the input_clock domain. The slow
// sample_clock is treated as data: it is synchronized, edge-detected into a
// one-cycle sample_tick, and every key FSM only moves on that tick.
//
// Optional feature macro: KEY_REPEAT_EN
//   When defined, a held key produces extra key_pressed strobes: the first
//   after REPEAT_DELAY held samples, then one every REPEAT_PERIOD samples.
//   When undefined, no repeat logic exists and key_pressed fires once per
//   accepted press.
//
// Parameters:
//   STABLE_SAMPLES  consecutive equal samples to accept a change (2..31)
//   REPEAT_DELAY    held samples before the first repeat strobe (1..1023)
//   REPEAT_PERIOD   samples between later repeat strobes (1..1023)
//
// Ports:
//   input_clock   system clock
//   reset_n       asynchronous active-low reset
//   sample_clock  ~1 kHz divided clock, used only as data
//   keys          key_debouncer_if.slave (key_n in; level/strobes/debug out)
// -----------------------------------------------------------------------------
module key_debouncer #(
   parameter int STABLE_SAMPLES = 20,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_PERIOD  = 100
) (
   input  logic           input_clock,
   input  logic           reset_n,
   input  logic           sample_clock,
   key_debouncer_if.slave keys
);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [4:0] STABLE_LIM = 5'(STABLE_SAMPLES);

   // Elaboration-time guards on the legal parameter ranges.
   if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 31) begin : g_bad_stable
      $error("key_debouncer: STABLE_SAMPLES out of range 2..31");
   end
   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 1023) begin : g_bad_delay
      $error("key_debouncer: REPEAT_DELAY out of range 1..1023");
   end
   if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 1023) begin : g_bad_period
      $error("key_debouncer: REPEAT_PERIOD out of range 1..1023");
   end

   // ---------------------------------------------------------------------------
   // Synchronizers and sample tick
   // ---------------------------------------------------------------------------
   logic [1:0] samp_sync;
   logic       samp_prev;
   logic       sample_tick;
   logic [2:0] key_meta;
   logic [2:0] key_sync;

   // Key synchronizers reset to 1 (released, active-low) so no key can look
   // pressed straight out of reset.
   always_ff @(posedge input_clock or negedge reset_n) begin
      if (!reset_n) begin
         samp_sync   <= 2'b00;
         samp_prev   <= 1'b0;
         sample_tick <= 1'b0;
         key_meta    <= 3'b111;
         key_sync    <= 3'b111;
      end else begin
         samp_sync   <= {samp_sync[0], sample_clock};
         samp_prev   <= samp_sync[1];
         sample_tick <= samp_sync[1] & ~samp_prev;
         key_meta    <= keys.key_n;
         key_sync    <= key_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-key FSMs
   // ---------------------------------------------------------------------------
   state_t     state_q [3];
   state_t     state_d [3];
   logic [4:0] cnt_q   [3];
   logic [4:0] cnt_d   [3];
   logic [2:0] level;
   logic [2:0] press_evt;
   logic [2:0] release_evt;
   logic [2:0] rpt_evt;
   logic [2:0] pressed_q;
   logic [2:0] released_q;

   // State register
   always_ff @(posedge input_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= 5'd0;
         end
         pressed_q  <= 3'b000;
         released_q <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         pressed_q  <= press_evt | rpt_evt;
         released_q <= release_evt;
      end
   end

   // Next-state logic. key_sync is active-low, so a 0 bit is a pressed sample.
   always_comb begin
      logic [4:0] inc;
      inc = 5'd0;
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         // Saturating increment: the counter can never wrap back to 0.
         inc = (cnt_q[i] == 5'd31) ? cnt_q[i] : cnt_q[i] + 5'd1;
         if (sample_tick) begin
            case (state_q[i])
               RELEASED: begin
                  if (!key_sync[i]) begin
                     state_d[i] = PRESS_WAIT;
                     cnt_d[i]   = 5'd1;
                  end
               end
               PRESS_WAIT: begin
                  if (!key_sync[i]) begin
                     if (inc == STABLE_LIM) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = 5'd0;
                     end else begin
                        cnt_d[i]   = inc;
                     end
                  end else begin
                     state_d[i] = RELEASED;
                     cnt_d[i]   = 5'd0;
                  end
               end
               PRESSED: begin
                  if (key_sync[i]) begin
                     state_d[i] = RELEASE_WAIT;
                     cnt_d[i]   = 5'd1;
                  end
               end
               RELEASE_WAIT: begin
                  if (key_sync[i]) begin
                     if (inc == STABLE_LIM) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = 5'd0;
                     end else begin
                        cnt_d[i]   = inc;
                     end
                  end else begin
                     state_d[i] = PRESSED;
                     cnt_d[i]   = 5'd0;
                  end
               end
               default: begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = 5'd0;
               end
            endcase
         end
      end
   end

   // Output decode. Events only arise from the completing transitions, which
   // themselves only happen on a tick, so every strobe follows a tick edge.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         level[i]       = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
         press_evt[i]   = (state_q[i] == PRESS_WAIT)   && (state_d[i] == PRESSED);
         release_evt[i] = (state_q[i] == RELEASE_WAIT) && (state_d[i] == RELEASED);
      end
   end

   // ---------------------------------------------------------------------------
   // Auto-repeat
   // ---------------------------------------------------------------------------
`ifdef KEY_REPEAT_EN
   localparam logic [9:0] DELAY_LIM  = 10'(REPEAT_DELAY);
   localparam logic [9:0] PERIOD_LIM = 10'(REPEAT_PERIOD);

   logic [9:0] rpt_q [3];
   logic [9:0] rpt_d [3];
   logic [2:0] rep_q;     // 1 once the initial delay has elapsed
   logic [2:0] rep_d;

   always_ff @(posedge input_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            rpt_q[i] <= 10'd0;
         end
         rep_q <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            rpt_q[i] <= rpt_d[i];
         end
         rep_q <= rep_d;
      end
   end

   // The counter restarts from 0 at every strobe and targets DELAY first,
   // then PERIOD, so it never needs more than 10 bits. Ticks that leave or
   // return from RELEASE_WAIT do not count, which freezes it while waiting.
   always_comb begin
      logic [9:0] nxt;
      nxt = 10'd0;
      for (int i = 0; i < 3; i++) begin
         rpt_d[i]   = rpt_q[i];
         rep_d[i]   = rep_q[i];
         rpt_evt[i] = 1'b0;
         if (press_evt[i]) begin
            rpt_d[i] = 10'd0;
            rep_d[i] = 1'b0;
         end else if (sample_tick && (state_q[i] == PRESSED) &&
                      (state_d[i] == PRESSED)) begin
            nxt = rpt_q[i] + 10'd1;
            if (nxt == (rep_q[i] ? PERIOD_LIM : DELAY_LIM)) begin
               rpt_evt[i] = 1'b1;
               rpt_d[i]   = 10'd0;
               rep_d[i]   = 1'b1;
            end else begin
               rpt_d[i]   = nxt;
            end
         end
      end
   end
`else
   assign rpt_evt = 3'b000;
`endif

   assign keys.key_level    = level;
   assign keys.key_pressed  = pressed_q;
   assign keys.key_released = released_q;
   assign keys.fsm_state    = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
// Directed bench for key_debouncer with STABLE_SAMPLES = 4, REPEAT_DELAY = 5,
// REPEAT_PERIOD = 2. The bench drives sample_clock itself; each raised edge
// is queued with the key vector it samples and the cycle on which its effect
// must appear. A per-key model (accepted level + run length of disagreeing
// samples + hold count) predicts level and strobes for every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_debouncer;

   localparam int STABLE = 4;
   localparam int RDELAY = 5;
   localparam int RPER   = 2;
   // Posedges from raising sample_clock to the edge that updates outputs:
   // two synchronizer flops, the tick register, then the FSM register.
   localparam int LAT    = 4;

   // ---------------------------------------------------------------- clock/reset
   logic input_clock = 1'b0;
   logic reset_n     = 1'b0;
   logic sample_clock = 1'b0;

   always #10 input_clock = ~input_clock;

   key_debouncer_if kif ();

   key_debouncer #(
      .STABLE_SAMPLES (STABLE),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .input_clock  (input_clock),
      .reset_n      (reset_n),
      .sample_clock (sample_clock),
      .keys         (kif.slave)
   );

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // {due cycle, pressed-sample vector}
   logic [34:0] exp_q [$];

   logic [2:0] m_acc;
   int         m_run  [3];
   int         m_hold [3];
   logic [2:0] exp_p;
   logic [2:0] exp_r;

   int         press_cnt [3];
   int         rel_cnt   [3];
   logic [2:0] last_press_vec = 3'b000;
   logic [2:0] last_rel_vec   = 3'b000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit repeat_due(input int h);
`ifdef KEY_REPEAT_EN
      return (h == RDELAY) || (h > RDELAY && ((h - RDELAY) % RPER) == 0);
`else
      return (h < 0);
`endif
   endfunction

   task automatic model_reset();
      m_acc = 3'b000;
      for (int i = 0; i < 3; i++) begin
         m_run[i]  = 0;
         m_hold[i] = 0;
      end
   endtask

   // One sample per key: a change is accepted after STABLE consecutive
   // samples that disagree with the accepted level; any agreeing sample
   // discards the partial run.
   task automatic model_step(input logic [2:0] smp);
      for (int i = 0; i < 3; i++) begin
         if (smp[i] == m_acc[i]) begin
            if (m_acc[i] && m_run[i] == 0) begin
               m_hold[i]++;
               if (repeat_due(m_hold[i])) exp_p[i] = 1'b1;
            end
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
               m_acc[i]  = smp[i];
               m_run[i]  = 0;
               m_hold[i] = 0;
               if (smp[i]) exp_p[i] = 1'b1;
               else        exp_r[i] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 3; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
      end
   end

   // Compare process: every cycle, 1 ns after the active edge.
   always @(posedge input_clock) begin
      logic [34:0] e;
      #1;
      cyc++;
      exp_p = 3'b000;
      exp_r = 3'b000;
      if (!reset_n) begin
         model_reset();
         exp_q.delete();
      end else if (exp_q.size() > 0) begin
         e = exp_q[0];
         if (e[34:3] == 32'(cyc)) begin
            void'(exp_q.pop_front());
            model_step(e[2:0]);
         end
      end
      check("key_level",    32'(kif.key_level),    32'(m_acc));
      check("key_pressed",  32'(kif.key_pressed),  32'(exp_p));
      check("key_released", 32'(kif.key_released), 32'(exp_r));
      for (int i = 0; i < 3; i++) begin
         if (kif.key_pressed[i])  press_cnt[i]++;
         if (kif.key_released[i]) rel_cnt[i]++;
      end
      if (kif.key_pressed  != 3'b000) last_press_vec = kif.key_pressed;
      if (kif.key_released != 3'b000) last_rel_vec   = kif.key_released;
   end

   // ---------------------------------------------------------------- drivers
   // One full sample period with key_n = kn (active-low). Keys settle before
   // sample_clock rises so the sample sees the new value.
   task automatic do_tick(input logic [2:0] kn);
      @(negedge input_clock);
      kif.key_n = kn;
      repeat (3) @(negedge input_clock);
      sample_clock = 1'b1;
      exp_q.push_back({32'(cyc + LAT), ~kn});
      repeat (4) @(negedge input_clock);
      sample_clock = 1'b0;
      repeat (3) @(negedge input_clock);
   endtask

   task automatic run_ticks(input logic [2:0] kn, input int n);
      for (int k = 0; k < n; k++) do_tick(kn);
   endtask

   task automatic pulse_reset();
      @(negedge input_clock);
      reset_n = 1'b0;
      #1;
      check("reset_level_now",   32'(kif.key_level),    32'h0);
      check("reset_pressed_now", 32'(kif.key_pressed),  32'h0);
      repeat (3) @(negedge input_clock);
      reset_n = 1'b1;
      repeat (3) @(negedge input_clock);
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [2:0] mix_tbl [14];
   int p0, p1, p2, r0;

   initial begin
      mix_tbl = '{3'b110, 3'b100, 3'b000, 3'b011, 3'b001, 3'b111, 3'b000,
                  3'b000, 3'b000, 3'b000, 3'b111, 3'b101, 3'b111, 3'b111};
      kif.key_n = 3'b111;
      repeat (3) @(negedge input_clock);
      check("reset_level",    32'(kif.key_level),    32'h0);
      check("reset_pressed",  32'(kif.key_pressed),  32'h0);
      check("reset_released", 32'(kif.key_released), 32'h0);
      reset_n = 1'b1;
      repeat (3) @(negedge input_clock);

      // Steady press on key 0: strobe only after the 4th sample.
      p0 = press_cnt[0];
      run_ticks(3'b110, 3);
      check("k0_no_early_press", 32'(press_cnt[0] - p0), 32'd0);
      check("k0_level_early",    32'(kif.key_level),     32'h0);
      do_tick(3'b110);
      check("k0_one_press",      32'(press_cnt[0] - p0), 32'd1);
      check("k0_level_set",      32'(kif.key_level),     32'h1);
      r0 = rel_cnt[0];
      run_ticks(3'b111, 4);
      check("k0_one_release",    32'(rel_cnt[0] - r0),   32'd1);
      check("k0_level_clear",    32'(kif.key_level),     32'h0);

      // Bouncing press on key 1.
      p1 = press_cnt[1];
      do_tick(3'b101);
      do_tick(3'b111);
      run_ticks(3'b101, 3);
      check("k1_bounce_no_press", 32'(press_cnt[1] - p1), 32'd0);
      do_tick(3'b101);
      check("k1_bounce_press",    32'(press_cnt[1] - p1), 32'd1);
      run_ticks(3'b111, 4);

      // Short release glitch while key 2 is held.
      p2 = press_cnt[2];
      run_ticks(3'b011, 4);
      run_ticks(3'b111, 2);
      run_ticks(3'b011, 2);
      check("k2_glitch_level",   32'(kif.key_level),   32'h4);
      check("k2_glitch_presses", 32'(press_cnt[2] - p2), 32'd1);
      check("k2_glitch_release", 32'(rel_cnt[2]),        32'd0);
      run_ticks(3'b111, 4);

      // All keys together.
      run_ticks(3'b000, 4);
      check("all_press_vec",   32'(last_press_vec), 32'h7);
      check("all_level",       32'(kif.key_level),  32'h7);
      run_ticks(3'b111, 4);
      check("all_release_vec", 32'(last_rel_vec),   32'h7);

      // Reset mid-debounce: acceptance restarts from zero.
      p0 = press_cnt[0];
      run_ticks(3'b110, 3);
      pulse_reset();
      run_ticks(3'b110, 3);
      check("rst_no_press",    32'(press_cnt[0] - p0), 32'd0);
      do_tick(3'b110);
      check("rst_press_after", 32'(press_cnt[0] - p0), 32'd1);
      run_ticks(3'b111, 4);

      // Mixed directed table, then settle everything released.
      foreach (mix_tbl[k]) do_tick(mix_tbl[k]);
      run_ticks(3'b111, 5);
      check("mix_settled", 32'(kif.key_level), 32'h0);

      // Long hold on key 0: 11 held samples beyond acceptance.
      p0 = press_cnt[0];
      run_ticks(3'b110, 4 + 11);
`ifdef KEY_REPEAT_EN
      check("hold_presses", 32'(press_cnt[0] - p0), 32'd5);
`else
      check("hold_presses", 32'(press_cnt[0] - p0), 32'd1);
`endif
      run_ticks(3'b111, 4);

      repeat (8) @(negedge input_clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #2ms;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter STABLE_SAMPLES, default 20, meaning consecutive equal samples required to accept a key change (legal 2..31).
REQ-002 SHALL have parameter REPEAT_DELAY, default 500, meaning samples held before the first auto-repeat pulse (legal 1..1023).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 100, meaning samples between later auto-repeat pulses (legal 1..1023).
REQ-004 SHALL have port input_clock, input, 1, the single system clock (50 MHz).
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sample_clock, input, 1, 1 kHz divided clock from the clock generator, used only as data.
REQ-007 SHALL have port key_n, input, 3, raw active-low push-buttons, asynchronous.
REQ-008 SHALL have port key_level, output, 3, debounced state per key, 1 = pressed.
REQ-009 SHALL have port key_pressed, output, 3, one-cycle pulse per accepted press (and auto-repeat).
REQ-010 SHALL have port key_released, output, 3, one-cycle pulse per accepted release.

Function
REQ-011 SHALL pass sample_clock and each key_n bit through a two-flop synchronizer clocked by input_clock.
REQ-012 SHALL generate sample_tick, a registered one-cycle pulse on each rising edge of synchronized sample_clock; no other clock domain permitted.
REQ-013 SHALL run an independent FSM per key with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT and a 5-bit stability counter; FSM advances only on cycles where sample_tick = 1.
REQ-014 RELEASED: pressed sample -> PRESS_WAIT, counter = 1; released sample -> stay.
REQ-015 PRESS_WAIT: pressed sample -> counter + 1; when counter + 1 = STABLE_SAMPLES -> PRESSED; released sample -> RELEASED, counter = 0, no pulse.
REQ-016 PRESSED: released sample -> RELEASE_WAIT, counter = 1; pressed sample -> stay.
REQ-017 RELEASE_WAIT: mirror of PRESS_WAIT; completion -> RELEASED; pressed sample -> PRESSED, no pulse.
REQ-018 On the tick edge entering PRESSED from PRESS_WAIT, key_level SHALL go 1 and key_pressed SHALL be 1 for exactly the following cycle; entering RELEASED from RELEASE_WAIT likewise drives key_level 0 and one key_released cycle.
REQ-019 key_level SHALL remain 1 throughout PRESSED and RELEASE_WAIT, 0 throughout RELEASED and PRESS_WAIT.
REQ-020 Simultaneous changes on several keys SHALL be handled independently in the same cycle; pulses may coincide.
REQ-021 Counters SHALL saturate, never wrap; pulses SHALL never exceed one cycle nor occur without a sample_tick on the preceding edge.

Reset
REQ-022 While reset_n = 0: all FSMs RELEASED, all counters 0, key_level/key_pressed/key_released = 0, key synchronizers = 1, sample_clock synchronizer and edge register = 0.
REQ-023 Reset assertion mid-debounce or mid-hold SHALL abort immediately with no pulse; after release a held key SHALL be re-accepted only after STABLE_SAMPLES full samples.

Configuration
REQ-024 With macro KEY_REPEAT_EN defined, each key SHALL own a 10-bit repeat counter, cleared on entering PRESSED from PRESS_WAIT, incremented per tick in PRESSED, frozen in RELEASE_WAIT; key_pressed pulses when it reaches REPEAT_DELAY, then every REPEAT_PERIOD ticks.
REQ-025 Without KEY_REPEAT_EN, no repeat logic SHALL be synthesized, REPEAT_DELAY/REPEAT_PERIOD are ignored, and key_pressed pulses once per accepted press.

Verification (STABLE_SAMPLES = 4, bench-driven sample_clock)
REQ-026 key_n[0] low steady, 4 ticks -> key_pressed[0] one cycle after 4th tick, key_level[0] = 1; no pulse after ticks 1-3.
REQ-027 key_n[1] bouncing low,high,low,low,low,low on 6 ticks -> single key_pressed[1] after 6th tick, none earlier.
REQ-028 key held, then high 2 ticks, low again -> key_level stays 1, no key_released, no second key_pressed (repeat off).
REQ-029 key_n = 3'b000 together, 4 ticks -> key_pressed = 3'b111 in the same cycle; released 4 ticks -> key_released = 3'b111 same cycle.
REQ-030 reset_n pulsed low after 3 pressed ticks, key kept low -> outputs 0 at once; key_pressed only after 4 further ticks.
REQ-031 KEY_REPEAT_EN, REPEAT_DELAY = 5, REPEAT_PERIOD = 2, key held 11 ticks beyond acceptance -> key_pressed pulses at acceptance and after held ticks 5, 7, 9, 11.
